// File: rtl/gpr_ea_file.sv
// General-purpose register file with a two-stage, handshaked multi-operand read-sum port.
// Optional GPR_BYPASS_EN: an operand matching a same-cycle write captures the new write data.
module gpr_ea_file #(
   parameter int DATA_W = 14,
   parameter int REG_N  = 16,
   parameter int REG_W  = 4,
   parameter int N_OPS  = 3
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     wr_en,
   input  logic [REG_W-1:0]         wr_addr,
   input  logic [DATA_W-1:0]        wr_data,
   input  logic                     rd_valid,
   output logic                     rd_ready,
   input  logic [N_OPS*REG_W-1:0]   rd_addr,
   output logic                     sum_valid,
   input  logic                     sum_ready,
   output logic [DATA_W-1:0]        sum_data,
   output logic                     sum_ovf
);

   localparam int SUM_W = DATA_W + 2;

   logic [DATA_W-1:0] r_regs   [REG_N];
   logic [DATA_W-1:0] r_s1_ops [N_OPS];
   logic              r_s1_valid;
   logic              r_sum_valid;
   logic [DATA_W-1:0] r_sum_data;
   logic              r_sum_ovf;

   logic [REG_W-1:0]  w_idx     [N_OPS];
   logic [DATA_W-1:0] w_capture [N_OPS];
   logic [SUM_W-1:0]  w_sum;
   logic              w_wr_hit;
   logic              w_s2_adv;
   logic              w_s1_adv;
   logic              w_accept;

   // Operand 0 sits in the most significant slice of rd_addr.
   for (genvar g = 0; g < N_OPS; g++) begin : g_idx
      assign w_idx[g] = rd_addr[(N_OPS-1-g)*REG_W +: REG_W];
   end

   assign w_wr_hit = wr_en && (int'(wr_addr) < REG_N);
   assign w_s2_adv = !r_sum_valid || sum_ready;
   assign w_s1_adv = r_s1_valid && w_s2_adv;
   assign rd_ready = !r_s1_valid || w_s2_adv;
   assign w_accept = rd_valid && rd_ready;

   // Out-of-range indices read as zero.
   always_comb begin
      for (int i = 0; i < N_OPS; i++) begin
         w_capture[i] = '0;
         if (int'(w_idx[i]) < REG_N) begin
            w_capture[i] = r_regs[w_idx[i]];
         end
`ifdef GPR_BYPASS_EN
         if (w_wr_hit && (wr_addr == w_idx[i])) begin
            w_capture[i] = wr_data;
         end
`endif
      end
   end

   // Two guard bits hold the carries of up to four operands.
   always_comb begin
      w_sum = '0;
      for (int i = 0; i < N_OPS; i++) begin
         w_sum = w_sum + {2'b00, r_s1_ops[i]};
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < REG_N; i++) begin
            r_regs[i] <= '0;
         end
         for (int i = 0; i < N_OPS; i++) begin
            r_s1_ops[i] <= '0;
         end
         r_s1_valid  <= 1'b0;
         r_sum_valid <= 1'b0;
         r_sum_data  <= '0;
         r_sum_ovf   <= 1'b0;
      end else begin
         if (w_wr_hit) begin
            r_regs[wr_addr] <= wr_data;
         end

         if (w_accept) begin
            for (int i = 0; i < N_OPS; i++) begin
               r_s1_ops[i] <= w_capture[i];
            end
            r_s1_valid <= 1'b1;
         end else if (w_s1_adv) begin
            r_s1_valid <= 1'b0;
         end

         // A refill of S2 takes priority over its consumption.
         if (w_s1_adv) begin
            r_sum_data  <= w_sum[DATA_W-1:0];
            r_sum_ovf   <= |w_sum[SUM_W-1:DATA_W];
            r_sum_valid <= 1'b1;
         end else if (r_sum_valid && sum_ready) begin
            r_sum_valid <= 1'b0;
         end
      end
   end

   assign sum_valid = r_sum_valid;
   assign sum_data  = r_sum_data;
   assign sum_ovf   = r_sum_ovf;

endmodule

// File: tb/tb_gpr_ea_file.sv
// Self-checking bench for gpr_ea_file: directed scenarios plus randomized traffic
// compared against a register-array / result-queue reference model.
module tb_gpr_ea_file;

   localparam int DATA_W = 14;
   localparam int REG_N  = 16;
   localparam int REG_W  = 4;
   localparam int N_OPS  = 3;

   logic                   clk;
   logic                   rst_n;
   logic                   wr_en;
   logic [REG_W-1:0]       wr_addr;
   logic [DATA_W-1:0]      wr_data;
   logic                   rd_valid;
   logic                   rd_ready;
   logic [N_OPS*REG_W-1:0] rd_addr;
   logic                   sum_valid;
   logic                   sum_ready;
   logic [DATA_W-1:0]      sum_data;
   logic                   sum_ovf;

   typedef struct {
      int unsigned sum;
      int          acc;
   } item_t;

   item_t             q[$];
   int unsigned       modelRegs [REG_N];
   int                compared;
   int                mismatched;
   int                cycleIdx;
   int                popCount;
   bit                lastAccept;
   bit                prevStall;
   logic [DATA_W-1:0] prevData;
   logic              prevOvf;

   gpr_ea_file #(
      .DATA_W(DATA_W), .REG_N(REG_N), .REG_W(REG_W), .N_OPS(N_OPS)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
      .sum_valid(sum_valid), .sum_ready(sum_ready),
      .sum_data(sum_data), .sum_ovf(sum_ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Global time limit so the run can never hang.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: observed timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      if (obs !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Plain-arithmetic sum of the requested registers as seen at the accept edge.
   function automatic int unsigned modelSum();
      int unsigned s;
      s = 0;
      for (int i = 0; i < N_OPS; i++) begin
         logic [REG_W-1:0] idx;
         int unsigned      v;
         idx = rd_addr[(N_OPS-1-i)*REG_W +: REG_W];
         v   = (int'(idx) < REG_N) ? modelRegs[idx] : 0;
`ifdef GPR_BYPASS_EN
         if (wr_en && (wr_addr == idx)) v = wr_data;
`endif
         s += v;
      end
      return s;
   endfunction

   // One clock cycle: check outputs mid-cycle against the model, then update it at the edge.
   task automatic applyStimulus();
      bit    expValid;
      item_t it;
      @(negedge clk);
      lastAccept = 1'b0;
      checkOutput("rd_ready", rd_ready, (q.size() < 2) || sum_ready);
      expValid = (q.size() > 0) && ((cycleIdx - q[0].acc) >= 2);
      checkOutput("sum_valid", sum_valid, expValid);
      if (prevStall) begin
         checkOutput("hold_data", sum_data, prevData);
         checkOutput("hold_ovf", sum_ovf, prevOvf);
      end
      if (sum_valid && (q.size() > 0)) begin
         checkOutput("sum_data", sum_data, q[0].sum & 32'h3FFF);
         checkOutput("sum_ovf", sum_ovf, q[0].sum > 32'h3FFF);
      end
      prevStall = rst_n && sum_valid && !sum_ready;
      prevData  = sum_data;
      prevOvf   = sum_ovf;
      if (rst_n) begin
         if (sum_valid && sum_ready && (q.size() > 0)) begin
            void'(q.pop_front());
            popCount++;
         end
         if (rd_valid && rd_ready) begin
            it.sum = modelSum();
            it.acc = cycleIdx;
            q.push_back(it);
            lastAccept = 1'b1;
         end
         if (wr_en && (int'(wr_addr) < REG_N)) modelRegs[wr_addr] = wr_data;
      end else begin
         q.delete();
         prevStall = 1'b0;
         for (int i = 0; i < REG_N; i++) modelRegs[i] = 0;
      end
      @(posedge clk);
      #1;
      cycleIdx++;
   endtask

   task automatic writeReg(input logic [REG_W-1:0] a, input logic [DATA_W-1:0] d);
      wr_en   = 1'b1;
      wr_addr = a;
      wr_data = d;
      applyStimulus();
      wr_en   = 1'b0;
   endtask

   // Single request with no backpressure: checks accept, two-cycle latency and the result.
   task automatic runOne(input string tag, input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] c, input logic [DATA_W-1:0] expD, input logic expO);
      sum_ready = 1'b1;
      rd_valid  = 1'b1;
      rd_addr   = {a, b, c};
      applyStimulus();
      checkOutput({tag, "_accept"}, lastAccept, 1);
      checkOutput({tag, "_early"}, sum_valid, 0);
      rd_valid = 1'b0;
      applyStimulus();
      checkOutput({tag, "_valid"}, sum_valid, 1);
      checkOutput({tag, "_data"}, sum_data, expD);
      checkOutput({tag, "_ovf"}, sum_ovf, expO);
      applyStimulus();
   endtask

   initial begin
      int          reqIdx;
      int          popBase;
      int          guard;
      logic [3:0]  k;
      compared   = 0;
      mismatched = 0;
      cycleIdx   = 0;
      popCount   = 0;
      prevStall  = 1'b0;
      for (int i = 0; i < REG_N; i++) modelRegs[i] = 0;
      rst_n     = 1'b0;
      wr_en     = 1'b0;
      wr_addr   = '0;
      wr_data   = '0;
      rd_valid  = 1'b0;
      rd_addr   = '0;
      sum_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;

      $display("[TB] reset state");
      checkOutput("rst_sum_valid", sum_valid, 0);
      checkOutput("rst_sum_data", sum_data, 0);
      checkOutput("rst_sum_ovf", sum_ovf, 0);
      checkOutput("rst_rd_ready", rd_ready, 1);
      runOne("zero", 4'd0, 4'd1, 4'd2, 14'h0000, 1'b0);

      $display("[TB] basic sum");
      writeReg(4'd1, 14'h0010);
      writeReg(4'd2, 14'h0100);
      writeReg(4'd3, 14'h0005);
      runOne("basic", 4'd1, 4'd2, 4'd3, 14'h0115, 1'b0);

      $display("[TB] overflow");
      writeReg(4'd4, 14'h3FFF);
      writeReg(4'd5, 14'h3FFF);
      writeReg(4'd6, 14'h3FFF);
      runOne("ovf", 4'd4, 4'd5, 4'd6, 14'h3FFD, 1'b1);
      runOne("repeat", 4'd1, 4'd1, 4'd1, 14'h0030, 1'b0);

      $display("[TB] same-edge write and accept");
      writeReg(4'd7, 14'h0001);
      wr_en    = 1'b1;
      wr_addr  = 4'd7;
      wr_data  = 14'h0002;
      rd_valid = 1'b1;
      rd_addr  = {4'd7, 4'd0, 4'd0};
      applyStimulus();
      wr_en    = 1'b0;
      rd_valid = 1'b0;
      applyStimulus();
      checkOutput("bypass_valid", sum_valid, 1);
`ifdef GPR_BYPASS_EN
      checkOutput("bypass_data", sum_data, 14'h0002);
`else
      checkOutput("bypass_data", sum_data, 14'h0001);
`endif
      applyStimulus();
      runOne("r7_after", 4'd7, 4'd0, 4'd0, 14'h0002, 1'b0);

      $display("[TB] backpressure");
      sum_ready = 1'b0;
      reqIdx    = 0;
      popBase   = popCount;
      for (int c = 0; c < 5; c++) begin
         k        = reqIdx[3:0];
         rd_valid = 1'b1;
         rd_addr  = {k + 4'd1, k + 4'd2, k + 4'd4};
         applyStimulus();
         if (lastAccept) reqIdx++;
      end
      checkOutput("bp_accepts", reqIdx, 2);
      checkOutput("bp_rd_ready_low", rd_ready, 0);
      sum_ready = 1'b1;
      guard     = 0;
      while ((reqIdx < 4) && (guard < 20)) begin
         k       = reqIdx[3:0];
         rd_addr = {k + 4'd1, k + 4'd2, k + 4'd4};
         applyStimulus();
         if (lastAccept) reqIdx++;
         guard++;
      end
      rd_valid = 1'b0;
      guard    = 0;
      while ((q.size() > 0) && (guard < 20)) begin
         applyStimulus();
         guard++;
      end
      checkOutput("bp_all_accepted", reqIdx, 4);
      checkOutput("bp_drained", q.size(), 0);
      checkOutput("bp_pops", popCount - popBase, 4);

      $display("[TB] reset with pipeline full");
      sum_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         rd_valid = 1'b1;
         rd_addr  = 12'($urandom);
         applyStimulus();
      end
      checkOutput("full_sum_valid", sum_valid, 1);
      checkOutput("full_rd_ready", rd_ready, 0);
      rst_n = 1'b0;
      applyStimulus();
      rst_n     = 1'b1;
      rd_valid  = 1'b0;
      sum_ready = 1'b1;
      checkOutput("postrst_sum_valid", sum_valid, 0);
      applyStimulus();
      applyStimulus();
      checkOutput("postrst_no_stale", sum_valid, 0);
      for (int r = 0; r < REG_N; r += 3) begin
         k = 4'(r);
         runOne("clr", k, k + 4'd1, k + 4'd2, 14'h0000, 1'b0);
      end

      $display("[TB] randomized traffic");
      for (int c = 0; c < 3000; c++) begin
         wr_en     = 1'($urandom_range(0, 1));
         wr_addr   = 4'($urandom);
         wr_data   = ($urandom_range(0, 3) == 0) ? 14'h3FFF : 14'($urandom);
         rd_valid  = ($urandom_range(0, 3) != 0);
         rd_addr   = 12'($urandom);
         sum_ready = ($urandom_range(0, 9) < 7);
         applyStimulus();
      end
      wr_en     = 1'b0;
      rd_valid  = 1'b0;
      sum_ready = 1'b1;
      guard     = 0;
      while ((q.size() > 0) && (guard < 20)) begin
         applyStimulus();
         guard++;
      end
      checkOutput("final_drained", q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
